hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It keeps its own shadow record of every in-flight register write in the E, M and W stages. For each D-stage instruction it computes the D-stage forwarding selects `FSel1_D` and `FSel2_D` consumed by the D-stage operand muxes, and decides whether D must stall. It sits directly upstream of those muxes and of the F/D and D/E pipeline registers.

---
 rtl/hz_pkg.sv | 43 ++++
 rtl/hz_fwd_pick.sv | 42 ++++
 rtl/hazard_ctrl.sv | 72 +++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hz_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, result kinds
// and the in-flight write record.
package hz_pkg;

   localparam logic [2:0] FS_PC8_E = 3'b000;
   localparam logic [2:0] FS_PC8_M = 3'b001;
   localparam logic [2:0] FS_ALU_M = 3'b010;
   localparam logic [2:0] FS_RES_W = 3'b011;
   localparam logic [2:0] FS_RF    = 3'b100;

   localparam logic [1:0] SRC_LINK = 2'b00;
   localparam logic [1:0] SRC_ALU  = 2'b01;
   localparam logic [1:0] SRC_MEM  = 2'b10;

   localparam logic [1:0] TUSE_NONE = 2'd3;

   localparam int REG_W  = 5;
   localparam int SRC_W  = 2;
   localparam int TNEW_W = 2;
   localparam int REC_W  = REG_W + SRC_W + TNEW_W;

   typedef struct packed {
      logic [REG_W-1:0]  dst;
      logic [SRC_W-1:0]  src;
      logic [TNEW_W-1:0] tnew;
   } rec_t;

   localparam rec_t REC_BUBBLE = '{dst: '0, src: SRC_LINK, tnew: '0};

   // Cycles a producer still needs once it sits in E.
   function automatic logic [TNEW_W-1:0] tnew_of(input logic [SRC_W-1:0] src);
      case (src)
         SRC_ALU: tnew_of = 2'd1;
         SRC_MEM: tnew_of = 2'd2;
         default: tnew_of = 2'd0;
      endcase
   endfunction

   function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
      tnew_dec = (t == '0) ? '0 : t - 2'd1;
   endfunction

endpackage

// File: rtl/hz_fwd_pick.sv
// Per-operand forwarding/stall decision: nearest matching stage (E, M, W) wins.
module hz_fwd_pick
   import hz_pkg::*;
(
   input  logic [REG_W-1:0]  reg_i,
   input  logic [1:0]        tuse_i,
   input  logic [REG_W-1:0]  e_dst_i,
   input  logic [TNEW_W-1:0] e_tnew_i,
   input  logic [REG_W-1:0]  m_dst_i,
   input  logic [SRC_W-1:0]  m_src_i,
   input  logic [TNEW_W-1:0] m_tnew_i,
   input  logic [REG_W-1:0]  w_dst_i,
   output logic [2:0]        fsel_o,
   output logic              stall_o
);

   logic rd_live;
   logic hit_e, hit_m, hit_w;

   assign rd_live = (reg_i != '0) && (tuse_i != TUSE_NONE);
   assign hit_e   = (e_dst_i == reg_i);
   assign hit_m   = (m_dst_i == reg_i);
   assign hit_w   = (w_dst_i == reg_i);

   always_comb begin
      fsel_o  = FS_RF;
      stall_o = 1'b0;
      if (rd_live) begin
         // A pending E producer shadows older stages even when it is not ready.
         if (hit_e) begin
            if (e_tnew_i == '0)         fsel_o  = FS_PC8_E;
            else if (tuse_i < e_tnew_i) stall_o = 1'b1;
         end else if (hit_m) begin
            if (m_tnew_i == '0)         fsel_o  = (m_src_i == SRC_LINK) ? FS_PC8_M : FS_ALU_M;
            else if (tuse_i < m_tnew_i) stall_o = 1'b1;
         end else if (hit_w) begin
            fsel_o = FS_RES_W;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: shadow records of E/M/W register writes, D-stage
// forwarding selects and load-use stall.
module hazard_ctrl
   import hz_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [1:0] Tuse_rs_D,
   input  logic [1:0] Tuse_rt_D,
   input  logic [4:0] dst_D,
   input  logic [1:0] src_D,
   output logic       stall,
   output logic [2:0] FSel1_D,
   output logic [2:0] FSel2_D
);

   rec_t             rec_e_q, rec_m_q;
   rec_t             rec_e_d, rec_m_d;
   logic [REG_W-1:0] rec_w_dst_q;
   logic             stall_rs, stall_rt;

   hz_fwd_pick u_pick_rs (
      .reg_i    (rs_D),
      .tuse_i   (Tuse_rs_D),
      .e_dst_i  (rec_e_q.dst),
      .e_tnew_i (rec_e_q.tnew),
      .m_dst_i  (rec_m_q.dst),
      .m_src_i  (rec_m_q.src),
      .m_tnew_i (rec_m_q.tnew),
      .w_dst_i  (rec_w_dst_q),
      .fsel_o   (FSel1_D),
      .stall_o  (stall_rs)
   );

   hz_fwd_pick u_pick_rt (
      .reg_i    (rt_D),
      .tuse_i   (Tuse_rt_D),
      .e_dst_i  (rec_e_q.dst),
      .e_tnew_i (rec_e_q.tnew),
      .m_dst_i  (rec_m_q.dst),
      .m_src_i  (rec_m_q.src),
      .m_tnew_i (rec_m_q.tnew),
      .w_dst_i  (rec_w_dst_q),
      .fsel_o   (FSel2_D),
      .stall_o  (stall_rt)
   );

   assign stall = stall_rs | stall_rt;

   // Tnew held in E is the producer's remaining latency counted from E.
   always_comb begin
      rec_e_d = stall ? REC_BUBBLE : rec_t'{dst: dst_D, src: src_D, tnew: tnew_of(src_D)};
      rec_m_d = rec_e_q;
      rec_m_d.tnew = tnew_dec(rec_e_q.tnew);
   end

   // The W stage only ever forwards Result_W, so only its dst is kept.
   always_ff @(posedge clk) begin
      if (reset) begin
         rec_e_q     <= REC_BUBBLE;
         rec_m_q     <= REC_BUBBLE;
         rec_w_dst_q <= '0;
      end else begin
         rec_e_q     <= rec_e_d;
         rec_m_q     <= rec_m_d;
         rec_w_dst_q <= rec_m_q.dst;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus random instruction
// streams, checked against an age-based model of in-flight producers.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] rs_D, rt_D, dst_D;
   logic [1:0] Tuse_rs_D, Tuse_rt_D, src_D;
   logic       stall;
   logic [2:0] FSel1_D, FSel2_D;

   int checks = 0;
   int failures = 0;

   // Model: producers by age (0 = E, 1 = M, 2 = W); a bubble has dst 0.
   logic [4:0] m_dst [3];
   logic [1:0] m_src [3];
   logic       m_stall;

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .rs_D      (rs_D),
      .rt_D      (rt_D),
      .Tuse_rs_D (Tuse_rs_D),
      .Tuse_rt_D (Tuse_rt_D),
      .dst_D     (dst_D),
      .src_D     (src_D),
      .stall     (stall),
      .FSel1_D   (FSel1_D),
      .FSel2_D   (FSel2_D)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void m_pick(input logic [4:0] r, input logic [1:0] tu,
                                  output logic [2:0] fs, output logic st);
      int lat, rem;
      fs = 3'd4;
      st = 1'b0;
      if (r == 5'd0 || tu == 2'd3) return;
      for (int a = 0; a < 3; a++) begin
         if (m_dst[a] == r) begin
            lat = (m_src[a] == 2'd2) ? 2 : (m_src[a] == 2'd1) ? 1 : 0;
            rem = (lat > a) ? lat - a : 0;
            if (a == 2)             fs = 3'd3;
            else if (rem == 0)      fs = (a == 0) ? 3'd0 : ((m_src[a] == 2'd0) ? 3'd1 : 3'd2);
            else if (int'(tu) < rem) st = 1'b1;
            return;
         end
      end
   endfunction

   task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tur,
                        input logic [1:0] tut, input logic [4:0] dst, input logic [1:0] src);
      rs_D = rs; rt_D = rt; Tuse_rs_D = tur; Tuse_rt_D = tut; dst_D = dst; src_D = src;
   endtask

   task automatic idle();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd1);
   endtask

   // One cycle: model check, optional constant checks, clock edge, model advance.
   task automatic step(input bit cs, input logic es, input bit c1, input logic [2:0] e1,
                       input bit c2, input logic [2:0] e2);
      logic [2:0] f1, f2;
      logic s1, s2;
      #1;
      m_pick(rs_D, Tuse_rs_D, f1, s1);
      m_pick(rt_D, Tuse_rt_D, f2, s2);
      m_stall = s1 | s2;
      if (!reset) begin
         chk("stall", {7'd0, stall}, {7'd0, m_stall});
         if (!m_stall) begin
            chk("fsel1", {5'd0, FSel1_D}, {5'd0, f1});
            chk("fsel2", {5'd0, FSel2_D}, {5'd0, f2});
         end
         if (cs) chk("stall_dir", {7'd0, stall}, {7'd0, es});
         if (c1) chk("fsel1_dir", {5'd0, FSel1_D}, {5'd0, e1});
         if (c2) chk("fsel2_dir", {5'd0, FSel2_D}, {5'd0, e2});
      end
      @(posedge clk);
      if (reset) begin
         for (int a = 0; a < 3; a++) begin m_dst[a] = 5'd0; m_src[a] = 2'd0; end
      end else begin
         m_dst[2] = m_dst[1]; m_src[2] = m_src[1];
         m_dst[1] = m_dst[0]; m_src[1] = m_src[0];
         m_dst[0] = m_stall ? 5'd0 : dst_D;
         m_src[0] = m_stall ? 2'd0 : src_D;
      end
      #1;
   endtask

   task automatic step0();
      step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0);
   endtask

   task automatic flush();
      idle();
      for (int i = 0; i < 3; i++) step0();
   endtask

   function automatic logic [4:0] rnd_reg();
      case ($urandom_range(0, 5))
         0: rnd_reg = 5'd0;
         1: rnd_reg = 5'd1;
         2: rnd_reg = 5'd2;
         3: rnd_reg = 5'd8;
         4: rnd_reg = 5'd9;
         default: rnd_reg = 5'd31;
      endcase
   endfunction

   initial begin
      for (int a = 0; a < 3; a++) begin m_dst[a] = 5'd0; m_src[a] = 2'd0; end
      m_stall = 1'b0;
      reset = 1'b1;
      idle();
      step0();
      step0();
      reset = 1'b0;
      step(1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 3'd4);

      // ALU producer reaches M, then W
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1); step0();
      idle(); step0();
      set_d(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd1); step(1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 3'd0);
      set_d(5'd8, 5'd0, 2'd0, 2'd3, 5'd0, 2'd1); step(1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 3'd0);
      flush();

      // Load-use, Tuse 0: two stall cycles then W forward
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2); step0();
      set_d(5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 2'd1);
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      step(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd3);
      flush();

      // Load-use, Tuse 1: one stall cycle then register file
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2); step0();
      set_d(5'd0, 5'd9, 2'd3, 2'd1, 5'd0, 2'd1);
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      step(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd4);
      flush();

      // jal then jr: PC8 from E, then from M
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0); step0();
      set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd1); step(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0);
      idle(); step0();
      flush();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0); step0();
      idle(); step0();
      set_d(5'd31, 5'd0, 2'd0, 2'd3, 5'd0, 2'd1); step(1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 3'd0);
      flush();

      // dst 8 in E and W: E wins
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1); step0();
      idle(); step0();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1); step0();
      set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd0, 2'd1); step(1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 3'd0);
      flush();

      // write to $0 never matches
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2); step0();
      set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd1); step(1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 3'd4);
      flush();

      // rs == rt on a load: single stall, identical selects afterwards
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2); step0();
      set_d(5'd9, 5'd9, 2'd0, 2'd0, 5'd0, 2'd1);
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      step(1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 3'd3);
      flush();

      // reset during a load-use stall
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2); step0();
      set_d(5'd0, 5'd9, 2'd3, 2'd0, 5'd0, 2'd1);
      step(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0);
      reset = 1'b1; step0();
      reset = 1'b0;
      step(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd4);
      flush();

      // random instruction stream; a stalled D instruction is held
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 63) == 0);
         if (!m_stall || reset)
            set_d(rnd_reg(), rnd_reg(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  rnd_reg(), 2'($urandom_range(0, 2)));
         step0();
         if (reset) m_stall = 1'b0;
      end
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
